// File: rtl/pcie_ep_pkg.sv
// ============================================================================
// Module  : pcie_ep_pkg
// Brief   : Shared TLP field positions, config addresses and response codes
//           for the simplified PCIe endpoint target.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pcie_ep_pkg;

    localparam int TLP_CFG_BIT   = 31;
    localparam int TLP_WR_BIT    = 30;
    localparam int TLP_RSVD_MSB  = 29;
    localparam int TLP_RSVD_LSB  = 24;
    localparam int TLP_ADDR_MSB  = 23;
    localparam int TLP_ADDR_LSB  = 16;
    localparam int TLP_WDATA_MSB = 15;
    localparam int TLP_WDATA_LSB = 0;

    localparam int ADDR_W = TLP_ADDR_MSB - TLP_ADDR_LSB + 1;
    localparam int DATA_W = TLP_WDATA_MSB - TLP_WDATA_LSB + 1;

    localparam logic [7:0] CFG_ADDR_ID   = 8'h00;
    localparam logic [7:0] CFG_ADDR_CMD  = 8'h04;
    localparam logic [7:0] CFG_ADDR_BAR0 = 8'h10;

    localparam logic [31:0] RSP_ACK            = 32'h0000_0001;
    localparam logic [31:0] DEVICE_ID_DEFAULT  = 32'h1234_5678;

    typedef struct packed {
        logic              is_config;
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } tlp_req_t;

endpackage : pcie_ep_pkg

`default_nettype wire

// File: rtl/pcie_ep_mem.sv
// ============================================================================
// Module  : pcie_ep_mem
// Brief   : MEM_DEPTH x 16 storage with synchronous write, synchronous clear
//           and a combinational read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_ep_mem
    import pcie_ep_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_W-1:0] r_mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
        end else if (we_i) begin
            r_mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
        end
    end

    // Caller guarantees raddr_i is in range before using the data.
    assign rdata_o = r_mem_q[raddr_i[IDX_W-1:0]];

endmodule : pcie_ep_mem

`default_nettype wire

// File: rtl/pcie_endpoint.sv
// ============================================================================
// Module  : pcie_endpoint
// Brief   : Single-stage registered decode of request TLPs into config-space
//           or memory accesses, one 32-bit completion per request.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_endpoint
    import pcie_ep_pkg::*;
#(
    parameter logic [31:0] DEVICE_ID = DEVICE_ID_DEFAULT,
    parameter int          MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tlp_data,
    input  logic        tlp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_valid
);

    tlp_req_t          w_req;
    logic              w_unused_rsvd;
    logic              w_mem_in_range;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_rdata;

    logic [31:0]       r_rsp_data_q;
    logic [31:0]       w_rsp_data_d;
    logic              r_rsp_valid_q;
    logic              w_rsp_valid_d;
    logic [DATA_W-1:0] r_cmd_q;
    logic [DATA_W-1:0] w_cmd_d;
    logic [DATA_W-1:0] r_bar0_q;
    logic [DATA_W-1:0] w_bar0_d;

    assign w_req.is_config = tlp_data[TLP_CFG_BIT];
    assign w_req.is_write  = tlp_data[TLP_WR_BIT];
    assign w_req.addr      = tlp_data[TLP_ADDR_MSB:TLP_ADDR_LSB];
    assign w_req.wdata     = tlp_data[TLP_WDATA_MSB:TLP_WDATA_LSB];
    assign w_unused_rsvd   = ^tlp_data[TLP_RSVD_MSB:TLP_RSVD_LSB];

    assign w_mem_in_range = ({1'b0, w_req.addr} < 9'(MEM_DEPTH));

    pcie_ep_mem #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (w_mem_we),
        .waddr_i (w_req.addr),
        .wdata_i (w_req.wdata),
        .raddr_i (w_req.addr),
        .rdata_o (w_mem_rdata)
    );

    always_comb begin
        w_rsp_data_d  = r_rsp_data_q;
        w_rsp_valid_d = 1'b0;
        w_cmd_d       = r_cmd_q;
        w_bar0_d      = r_bar0_q;
        w_mem_we      = 1'b0;

        if (tlp_valid) begin
            w_rsp_valid_d = 1'b1;
            if (w_req.is_write) begin
                // Every write is acknowledged, even when it lands nowhere.
                w_rsp_data_d = RSP_ACK;
                if (w_req.is_config) begin
                    case (w_req.addr)
                        CFG_ADDR_CMD:  w_cmd_d  = w_req.wdata;
                        CFG_ADDR_BAR0: w_bar0_d = w_req.wdata;
                        default:       ;
                    endcase
                end else begin
                    w_mem_we = w_mem_in_range;
                end
            end else if (w_req.is_config) begin
                case (w_req.addr)
                    CFG_ADDR_ID:   w_rsp_data_d = DEVICE_ID;
                    CFG_ADDR_CMD:  w_rsp_data_d = {16'h0000, r_cmd_q};
                    CFG_ADDR_BAR0: w_rsp_data_d = {16'h0000, r_bar0_q};
                    default:       w_rsp_data_d = 32'h0000_0000;
                endcase
            end else begin
                w_rsp_data_d = w_mem_in_range ? {16'h0000, w_mem_rdata} : 32'h0000_0000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_data_q  <= '0;
            r_rsp_valid_q <= 1'b0;
            r_cmd_q       <= '0;
            r_bar0_q      <= '0;
        end else begin
            r_rsp_data_q  <= w_rsp_data_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_cmd_q       <= w_cmd_d;
            r_bar0_q      <= w_bar0_d;
        end
    end

    assign rsp_data  = r_rsp_data_q;
    assign rsp_valid = r_rsp_valid_q;

endmodule : pcie_endpoint

`default_nettype wire

// File: tb/tb_pcie_endpoint.sv
// ============================================================================
// Module  : tb_pcie_endpoint
// Brief   : Directed and randomized self-checking bench for pcie_endpoint.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcie_endpoint;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tlp_data;
    logic        tlp_valid;
    logic [31:0] rsp_data;
    logic        rsp_valid;

    int compared   = 0;
    int mismatched = 0;

    // Reference state of the target, in plain behavioural terms.
    logic [15:0] m_mem [256];
    logic [15:0] m_cmd;
    logic [15:0] m_bar0;
    logic [31:0] m_last_rsp;

    pcie_endpoint u_dut (
        .clk       (clk),
        .rst       (rst),
        .tlp_data  (tlp_data),
        .tlp_valid (tlp_valid),
        .rsp_data  (rsp_data),
        .rsp_valid (rsp_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 16'h0;
        m_cmd      = 16'h0;
        m_bar0     = 16'h0;
        m_last_rsp = 32'h0;
    endtask

    // Completion a target obeying the request rules must return; applies writes.
    function automatic logic [31:0] model_apply(input logic [31:0] t);
        logic        cfg = t[31];
        logic        wr  = t[30];
        logic [7:0]  a   = t[23:16];
        logic [15:0] d   = t[15:0];
        logic [31:0] r;
        if (wr) begin
            if (cfg) begin
                if (a == 8'h04) m_cmd = d;
                else if (a == 8'h10) m_bar0 = d;
            end else begin
                m_mem[a] = d;
            end
            r = 32'h1;
        end else if (cfg) begin
            if (a == 8'h00)      r = 32'h1234_5678;
            else if (a == 8'h04) r = {16'h0, m_cmd};
            else if (a == 8'h10) r = {16'h0, m_bar0};
            else                 r = 32'h0;
        end else begin
            r = {16'h0, m_mem[a]};
        end
        return r;
    endfunction

    // Present one request for one edge and check the completion.
    task automatic send(input string tag, input logic [31:0] t);
        logic [31:0] exp;
        tlp_data  = t;
        tlp_valid = 1'b1;
        exp = model_apply(t);
        @(posedge clk);
        #1;
        m_last_rsp = exp;
        check({tag, ".valid"}, {31'h0, rsp_valid}, 32'h1);
        check({tag, ".data"},  rsp_data, exp);
    endtask

    task automatic idle(input string tag);
        tlp_valid = 1'b0;
        tlp_data  = $urandom;
        @(posedge clk);
        #1;
        check({tag, ".valid"}, {31'h0, rsp_valid}, 32'h0);
        check({tag, ".hold"},  rsp_data, m_last_rsp);
    endtask

    task automatic do_reset(input string tag, input logic with_req);
        rst       = 1'b1;
        tlp_valid = with_req;
        tlp_data  = 32'h4002_ABCD;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        tlp_valid = 1'b0;
        model_reset();
        check({tag, ".valid"}, {31'h0, rsp_valid}, 32'h0);
        check({tag, ".data"},  rsp_data, 32'h0);
    endtask

    initial begin
        logic [31:0] t;
        logic [7:0]  cfg_addrs [4];
        cfg_addrs[0] = 8'h00;
        cfg_addrs[1] = 8'h04;
        cfg_addrs[2] = 8'h10;
        cfg_addrs[3] = 8'h08;

        rst       = 1'b1;
        tlp_valid = 1'b0;
        tlp_data  = 32'h0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.valid", {31'h0, rsp_valid}, 32'h0);
        check("reset.data",  rsp_data, 32'h0);

        send("t1.id_read", 32'h8000_0000);
        idle("t1.pulse");

        send("t2.bar0_wr", 32'hC010_1234);
        send("t2.bar0_rd", 32'h8010_0000);
        idle("t2.idle");

        send("t3.mem_wr", 32'h4002_5678);
        send("t3.mem_rd", 32'h0002_0000);
        idle("t3.idle");

        do_reset("t6.reset", 1'b1);
        send("t6.bar0_rd", 32'h8010_0000);
        send("t6.mem_rd",  32'h0002_0000);
        idle("t6.idle");

        send("t4.id_wr", 32'hC000_FFFF);
        send("t4.id_rd", 32'h8000_0000);
        idle("t4.idle");

        send("t5.b2b_wr", 32'h4005_BEEF);
        send("t5.b2b_rd", 32'h0005_0000);
        idle("t5.idle");

        send("cmd.wr",   32'hC004_A5A5);
        send("cmd.rd",   32'h8004_0000);
        send("cfg.other_wr", 32'hC020_1111);
        send("cfg.other_rd", 32'h8020_0000);
        send("mem.top_wr", 32'h40FF_C0DE);
        send("mem.top_rd", 32'h00FF_0000);
        send("rsvd.ignored", 32'h3FFF_0000);

        for (int i = 0; i < 400; i++) begin
            t = $urandom;
            if (t[31]) t[23:16] = cfg_addrs[$urandom_range(0, 3)];
            else       t[23:16] = 8'($urandom_range(0, 15) * 16 + $urandom_range(0, 3));
            send("rand.req", t);
            if ($urandom_range(0, 3) == 0) idle("rand.idle");
            if (i == 200) do_reset("rand.reset", 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit expired");
    end

endmodule : tb_pcie_endpoint

`default_nettype wire
